// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, 32x32 register file with
// optional write-back bypass, immediate generation, source-use decode and
// load-use hazard detection.
//
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   PC_IF, PC4_IF, IDATA_IF     fetched PC, PC+4 and instruction
//   isBranch_E                  taken branch/jump in EX, flushes this stage
//   MEMREAD_E, RD_E             load in EX and its destination (hazard check)
//   RWE_W, RD_W, RDATA_W        register-file write-back port
//   STALL_ID                    hold fetch PC and IF/ID register this cycle
//   VALID_ID                    ID content is issued to EX this cycle
//   PC_ID, PC4_ID, IR_ID        registered PC, PC+4, instruction
//   RS1_ID, RS2_ID, RD_ID       register index fields of IR_ID
//   RS1DATA_ID, RS2DATA_ID      source operands
//   IMM_ID                      sign-extended immediate
//   ILLEGAL_ID                  opcode outside RV32I while the stage is valid
module id_stage #(
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter bit          RF_BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC_IF,
    input  logic [31:0] PC4_IF,
    input  logic [31:0] IDATA_IF,
    input  logic        isBranch_E,
    input  logic        MEMREAD_E,
    input  logic [4:0]  RD_E,
    input  logic        RWE_W,
    input  logic [4:0]  RD_W,
    input  logic [31:0] RDATA_W,
    output logic        STALL_ID,
    output logic        VALID_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] PC4_ID,
    output logic [31:0] IR_ID,
    output logic [4:0]  RS1_ID,
    output logic [4:0]  RS2_ID,
    output logic [4:0]  RD_ID,
    output logic [31:0] RS1DATA_ID,
    output logic [31:0] RS2DATA_ID,
    output logic [31:0] IMM_ID,
    output logic        ILLEGAL_ID
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic [31:0] ir_q;
    logic [31:0] regs_q [32];

    logic [6:0]  opcode;
    logic        rs1_used;
    logic        rs2_used;
    logic        legal;
    logic [31:0] imm;
    logic        wb_hit;

    // IF/ID register: flush has priority over stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            ir_q    <= NOP_INST;
        end else if (isBranch_E) begin
            valid_q <= 1'b0;
            ir_q    <= NOP_INST;
        end else if (!STALL_ID) begin
            valid_q <= 1'b1;
            pc_q    <= PC_IF;
            pc4_q   <= PC4_IF;
            ir_q    <= IDATA_IF;
        end
    end

    // Register file; x0 is never written so it always holds zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RWE_W && (RD_W != 5'd0)) begin
            regs_q[RD_W] <= RDATA_W;
        end
    end

    assign opcode = ir_q[6:0];
    assign RS1_ID = ir_q[19:15];
    assign RS2_ID = ir_q[24:20];
    assign RD_ID  = ir_q[11:7];
    assign wb_hit = RWE_W && (RD_W != 5'd0);

    always_comb begin
        RS1DATA_ID = '0;
        RS2DATA_ID = '0;
        if (RS1_ID != 5'd0) begin
            if (RF_BYPASS && wb_hit && (RD_W == RS1_ID)) RS1DATA_ID = RDATA_W;
            else                                          RS1DATA_ID = regs_q[RS1_ID];
        end
        if (RS2_ID != 5'd0) begin
            if (RF_BYPASS && wb_hit && (RD_W == RS2_ID)) RS2DATA_ID = RDATA_W;
            else                                          RS2DATA_ID = regs_q[RS2_ID];
        end
    end

    // Opcode decode: source usage, legality and immediate format.
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        legal    = 1'b1;
        imm      = '0;
        case (opcode)
            OpLoad, OpImm, OpJalr: imm = {{20{ir_q[31]}}, ir_q[31:20]};
            OpStore: begin
                rs2_used = 1'b1;
                imm      = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            OpBranch: begin
                rs2_used = 1'b1;
                imm      = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            OpLui, OpAuipc: begin
                rs1_used = 1'b0;
                imm      = {ir_q[31:12], 12'b0};
            end
            OpJal: begin
                rs1_used = 1'b0;
                imm      = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            OpReg:             rs2_used = 1'b1;
            OpFence, OpSystem: ;
            default:           legal = 1'b0;
        endcase
    end

    assign IMM_ID     = imm;
    assign ILLEGAL_ID = valid_q & ~legal;

    // Load-use hazard; a flush kills the stalled instruction anyway.
    assign STALL_ID = valid_q & MEMREAD_E & (RD_E != 5'd0) & ~isBranch_E &
                      ((rs1_used & (RS1_ID == RD_E)) | (rs2_used & (RS2_ID == RD_E)));

    assign VALID_ID = valid_q & ~STALL_ID & ~isBranch_E;
    assign PC_ID    = pc_q;
    assign PC4_ID   = pc4_q;
    assign IR_ID    = ir_q;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] PC_IF, PC4_IF, IDATA_IF;
    logic        isBranch_E, MEMREAD_E;
    logic [4:0]  RD_E;
    logic        RWE_W;
    logic [4:0]  RD_W;
    logic [31:0] RDATA_W;

    logic        STALL_ID, VALID_ID, ILLEGAL_ID;
    logic [31:0] PC_ID, PC4_ID, IR_ID, RS1DATA_ID, RS2DATA_ID, IMM_ID;
    logic [4:0]  RS1_ID, RS2_ID, RD_ID;

    logic        nb_stall, nb_valid, nb_illegal;
    logic [31:0] nb_pc, nb_pc4, nb_ir, nb_rs1data, nb_rs2data, nb_imm;
    logic [4:0]  nb_rs1, nb_rs2, nb_rd;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] ADD  = 32'h003182B3;  // add x5,x3,x3
    localparam logic [31:0] ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] NOP  = 32'h00000013;

    always #5 CLK = ~CLK;

    id_stage dut (
        .CLK(CLK), .RST_N(RST_N), .PC_IF(PC_IF), .PC4_IF(PC4_IF), .IDATA_IF(IDATA_IF),
        .isBranch_E(isBranch_E), .MEMREAD_E(MEMREAD_E), .RD_E(RD_E),
        .RWE_W(RWE_W), .RD_W(RD_W), .RDATA_W(RDATA_W),
        .STALL_ID(STALL_ID), .VALID_ID(VALID_ID), .PC_ID(PC_ID), .PC4_ID(PC4_ID),
        .IR_ID(IR_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
        .RS1DATA_ID(RS1DATA_ID), .RS2DATA_ID(RS2DATA_ID), .IMM_ID(IMM_ID),
        .ILLEGAL_ID(ILLEGAL_ID)
    );

    id_stage #(.RF_BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N), .PC_IF(PC_IF), .PC4_IF(PC4_IF), .IDATA_IF(IDATA_IF),
        .isBranch_E(isBranch_E), .MEMREAD_E(MEMREAD_E), .RD_E(RD_E),
        .RWE_W(RWE_W), .RD_W(RD_W), .RDATA_W(RDATA_W),
        .STALL_ID(nb_stall), .VALID_ID(nb_valid), .PC_ID(nb_pc), .PC4_ID(nb_pc4),
        .IR_ID(nb_ir), .RS1_ID(nb_rs1), .RS2_ID(nb_rs2), .RD_ID(nb_rd),
        .RS1DATA_ID(nb_rs1data), .RS2DATA_ID(nb_rs2data), .IMM_ID(nb_imm),
        .ILLEGAL_ID(nb_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd_e;
        logic        stall;
    } haz_t;

    vec_t vecs[8];
    haz_t hazs[10];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        PC_IF    = pc;
        PC4_IF   = pc + 32'd4;
        IDATA_IF = inst;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, PC_ID, 32'h0);
        chk({tag, "_pc4"}, PC4_ID, 32'h0);
        chk({tag, "_ir"}, IR_ID, NOP);
        chk({tag, "_valid"}, {31'h0, VALID_ID}, 32'h0);
        chk({tag, "_stall"}, {31'h0, STALL_ID}, 32'h0);
        chk({tag, "_illegal"}, {31'h0, ILLEGAL_ID}, 32'h0);
        chk({tag, "_imm"}, IMM_ID, 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h10, ADDI,         32'h5,        1'b0, 5'd0, 5'd5, 5'd1};
        vecs[1] = '{32'h14, 32'hFE010FE3, 32'hFFFFFFFE, 1'b0, 5'd2, 5'd0, 5'd31};
        vecs[2] = '{32'h18, 32'h800000EF, 32'hFFF00000, 1'b0, 5'd0, 5'd0, 5'd1};
        vecs[3] = '{32'h1C, 32'hFFF12023, 32'hFFFFFFE0, 1'b0, 5'd2, 5'd31, 5'd0};
        vecs[4] = '{32'h20, 32'h0000007F, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0};
        vecs[5] = '{32'h24, 32'h000031B7, 32'h00003000, 1'b0, 5'd0, 5'd0, 5'd3};
        vecs[6] = '{32'h28, ADD,          32'h0,        1'b0, 5'd3, 5'd3, 5'd5};
        vecs[7] = '{32'h2C, 32'h00000073, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0};

        hazs[0] = '{ADD,          5'd0, 1'b0};  // RD_E = x0 never stalls
        hazs[1] = '{32'h000031B7, 5'd3, 1'b0};  // lui x3
        hazs[2] = '{32'h000181B7, 5'd3, 1'b0};  // lui, rs1 field = 3 but unused
        hazs[3] = '{32'h0001806F, 5'd3, 1'b0};  // jal, rs1 field = 3 but unused
        hazs[4] = '{32'h00018197, 5'd3, 1'b0};  // auipc, rs1 field = 3 but unused
        hazs[5] = '{32'h00300093, 5'd3, 1'b0};  // addi, rs2 field = 3 but unused
        hazs[6] = '{32'h00302023, 5'd3, 1'b1};  // sw x3 -> rs2 hit
        hazs[7] = '{32'h00300063, 5'd3, 1'b1};  // beq x0,x3 -> rs2 hit
        hazs[8] = '{32'h00018067, 5'd3, 1'b1};  // jalr via x3 -> rs1 hit
        hazs[9] = '{ADD,          5'd3, 1'b1};

        RST_N = 1'b0; isBranch_E = 1'b0; MEMREAD_E = 1'b0; RD_E = '0;
        RWE_W = 1'b0; RD_W = '0; RDATA_W = '0;
        fetch(32'h0, 32'h0);
        #12;
        chk_reset("rst");
        chk("rst_nb_ir", nb_ir, NOP);
        chk("rst_nb_pc", nb_pc ^ nb_pc4 ^ nb_imm ^ nb_rs2data, 32'h0);
        chk("rst_nb_flags", {29'h0, nb_stall, nb_valid, nb_illegal}, 32'h0);
        chk("rst_nb_fields", {17'h0, nb_rs1, nb_rs2, nb_rd}, 32'h0);

        @(negedge CLK);
        RST_N = 1'b1;

        // Table of single instructions through the IF/ID register.
        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].pc, vecs[i].inst);
            exp_q.push_back(vecs[i]);
            tick();
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'h0, 32'h1);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk($sformatf("v%0d_ir", i), IR_ID, e.inst);
                chk($sformatf("v%0d_pc", i), PC_ID, e.pc);
                chk($sformatf("v%0d_pc4", i), PC4_ID, e.pc + 32'd4);
                chk($sformatf("v%0d_imm", i), IMM_ID, e.imm);
                chk($sformatf("v%0d_ill", i), {31'h0, ILLEGAL_ID}, {31'h0, e.ill});
                chk($sformatf("v%0d_valid", i), {31'h0, VALID_ID}, 32'h1);
                chk($sformatf("v%0d_fields", i), {17'h0, RS1_ID, RS2_ID, RD_ID},
                    {17'h0, e.rs1, e.rs2, e.rd});
                chk($sformatf("v%0d_rs1d", i), RS1DATA_ID, 32'h0);
                chk($sformatf("v%0d_rs2d", i), RS2DATA_ID, 32'h0);
            end
        end

        // Same-cycle write-back bypass vs. no bypass.
        fetch(32'h30, ADD);
        tick();
        RWE_W = 1'b1; RD_W = 5'd3; RDATA_W = 32'hDEADBEEF;
        #1;
        chk("byp_rs1", RS1DATA_ID, 32'hDEADBEEF);
        chk("byp_rs2", RS2DATA_ID, 32'hDEADBEEF);
        chk("nobyp_rs1", nb_rs1data, 32'h0);
        chk("nobyp_rs2", nb_rs2data, 32'h0);
        tick();
        RWE_W = 1'b0;
        #1;
        chk("wr_rs1", RS1DATA_ID, 32'hDEADBEEF);
        chk("wr_nb_rs2", nb_rs2data, 32'hDEADBEEF);

        // Writes to x0 are dropped and never bypassed.
        fetch(32'h34, ADDI);
        RWE_W = 1'b1; RD_W = 5'd0; RDATA_W = 32'h1234;
        tick();
        chk("x0_byp", RS1DATA_ID, 32'h0);
        RWE_W = 1'b0;
        #1;
        chk("x0_rd", RS1DATA_ID, 32'h0);
        chk("x0_nb", nb_rs1data, 32'h0);

        // Load-use stall: one cycle, IR held, then the next instruction.
        fetch(32'h40, ADD);
        tick();
        fetch(32'h44, ADDI);
        MEMREAD_E = 1'b1; RD_E = 5'd3;
        #1;
        chk("lu_stall", {31'h0, STALL_ID}, 32'h1);
        chk("lu_valid", {31'h0, VALID_ID}, 32'h0);
        tick();
        MEMREAD_E = 1'b0;
        #1;
        chk("lu_hold_ir", IR_ID, ADD);
        chk("lu_hold_pc", PC_ID, 32'h40);
        chk("lu_after_valid", {31'h0, VALID_ID}, 32'h1);
        chk("lu_after_stall", {31'h0, STALL_ID}, 32'h0);
        tick();
        chk("lu_next_ir", IR_ID, ADDI);
        chk("lu_next_pc", PC_ID, 32'h44);

        // Source-usage decode of the hazard check.
        for (int i = 0; i < 10; i++) begin
            MEMREAD_E = 1'b0;
            fetch(32'h100 + 32'(i * 4), hazs[i].inst);
            tick();
            MEMREAD_E = 1'b1; RD_E = hazs[i].rd_e;
            #1;
            chk($sformatf("hz%0d_stall", i), {31'h0, STALL_ID}, {31'h0, hazs[i].stall});
            chk($sformatf("hz%0d_valid", i), {31'h0, VALID_ID}, {31'h0, ~hazs[i].stall});
        end
        MEMREAD_E = 1'b0;

        // Flush beats stall.
        fetch(32'h80, ADD);
        tick();
        fetch(32'h84, ADDI);
        MEMREAD_E = 1'b1; RD_E = 5'd3; isBranch_E = 1'b1;
        #1;
        chk("fl_stall", {31'h0, STALL_ID}, 32'h0);
        chk("fl_valid", {31'h0, VALID_ID}, 32'h0);
        tick();
        isBranch_E = 1'b0; MEMREAD_E = 1'b0;
        #1;
        chk("fl_ir", IR_ID, NOP);
        chk("fl_valid_next", {31'h0, VALID_ID}, 32'h0);
        tick();
        chk("fl_resume_ir", IR_ID, ADDI);
        chk("fl_resume_valid", {31'h0, VALID_ID}, 32'h1);

        // Asynchronous reset in the middle of a stall.
        fetch(32'h90, ADD);
        tick();
        MEMREAD_E = 1'b1; RD_E = 5'd3;
        #1;
        chk("ar_stall_pre", {31'h0, STALL_ID}, 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset("ar");
        MEMREAD_E = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        fetch(32'hA0, ADD);
        tick();
        chk("ar_rf_rs1", RS1DATA_ID, 32'h0);
        chk("ar_rf_rs2", RS2DATA_ID, 32'h0);
        chk("ar_valid", {31'h0, VALID_ID}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
